router_fsm_nch: RTL and testbench
=================================

Name: router_fsm_nch

Overview:
Parametrised controller FSM for a 1xN router; successor of the fixed 1x3 router controller. It sequences the header, payload and parity phases of each incoming packet and generates the load, write and busy controls for the synchroniser, register and FIFO stages. New over the 1x3 version:
- Channel count and address width are parameters.
- Packets with an invalid address are dropped.
- A bounded wait for the destination FIFO to drain, with a timeout error.

Parameters:
NUM_CH, 3, number of output channels / FIFOs (2..16).
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH.
WAIT_TIMEOUT, 30, max cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 = wait forever.

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
pkt_valid  in  1  packet byte valid from source.
parity_done  in  1  parity byte has been written (from register block).
low_pkt_valid  in  1  pkt_valid fell while FIFO was full (from register block).
data_in  in  ADDR_W  address field of header byte (data[ADDR_W-1:0]).
fifo_full  in  1  selected FIFO full (muxed by synchroniser).
fifo_empty  in  NUM_CH  per-FIFO empty flags.
soft_reset  in  NUM_CH  per-FIFO soft reset (read timeout) from synchroniser.
detect_add  out  1  in DECODE_ADDRESS.
lfd_state  out  1  in LOAD_FIRST_DATA.
ld_state  out  1  in LOAD_DATA.
laf_state  out  1  in LOAD_AFTER_FULL.
full_state  out  1  in FIFO_FULL_STATE.
write_enb_reg  out  1  write enable to FIFO.
rst_int_reg  out  1  in CHECK_PARITY_ERROR.
busy  out  1  stall source.
drop_state  out  1  in DROP_PACKET.
timeout_err  out  1  one-cycle pulse on wait timeout.
dest_addr  out  ADDR_W  latched destination of current packet.

Behaviour:
- Outputs are Moore, decoded from registered state only. Exceptions: timeout_err is a registered pulse; dest_addr is a register.
- Reset (reset=1 at rising edge):
  - state=DECODE_ADDRESS, wait counter=0, dest_addr=0, timeout_err=0.
  - Outputs after reset: detect_add=1, all others 0.
- DECODE_ADDRESS (DA):
  - Transitions apply only when pkt_valid=1; otherwise stay.
  - dest_addr<=data_in whenever pkt_valid=1.
  - data_in>=NUM_CH -> DROP_PACKET.
  - Valid address with fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - Valid address with fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY; counter cleared.
- WAIT_TILL_EMPTY (WTE):
  - fifo_empty[dest_addr]=1 -> LOAD_FIRST_DATA.
  - Else, if WAIT_TIMEOUT!=0 and counter==WAIT_TIMEOUT-1 -> DROP_PACKET, timeout_err=1 for the next cycle.
  - Else stay, counter+1. Counter saturates; never wraps.
- LOAD_FIRST_DATA (LFD) -> LOAD_DATA unconditionally.
- LOAD_DATA (LD):
  - fifo_full=1 -> FIFO_FULL_STATE (priority).
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE (FFS): fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL (LAF):
  - parity_done=1 -> DA (priority).
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LD.
- LOAD_PARITY (LP) -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR (CPE): fifo_full=1 -> FFS; else -> DA.
- DROP_PACKET (DP): pkt_valid=0 -> DA; else stay. No FIFO writes. The trailing parity byte is ignored because pkt_valid=0 in DA.
- Soft reset:
  - If soft_reset[dest_addr]=1 in WTE, LFD, LD, FFS, LAF, LP or CPE -> DA next cycle, overriding all other transitions. Counter is cleared.
  - Soft reset of a non-selected channel is ignored.
  - Soft reset is ignored in DA and DP.
  - reset overrides soft_reset.
- Output decode:
  - write_enb_reg=1 in LD, LAF, LP.
  - busy=1 in LFD, WTE, FFS, LAF, LP, CPE.
  - busy=0 in DA, LD, DP.
  - drop_state=1 only in DP.
- Latency: header accepted in DA -> lfd_state asserted next cycle when the FIFO is empty.
- Reset mid-packet: immediate return to DA. There is no recovery of the partial packet; the source must resend.

Test Plan:
- Reset then soft_reset[0], [1], [2] pulses while in DA -> detect_add=1 throughout, no state change, busy=0.
- Short packet, NUM_CH=3, data_in=2, fifo_empty=3'b100, pkt_valid held 3 cycles then 0 -> states DA,LFD,LD,LD,LP,CPE,DA. write_enb_reg=1 in LD/LP. rst_int_reg=1 for one cycle. dest_addr=2.
- data_in=1, fifo_empty[1]=0 for 5 cycles then 1 -> WTE for 5 cycles with busy=1, then LFD, no timeout_err. Repeat with fifo_empty[1] held 0, WAIT_TIMEOUT=30 -> DP entered after 30 WTE cycles, timeout_err pulses once.
- LD with fifo_full=1 for 2 cycles, then parity_done=0, low_pkt_valid=1 -> LD,FFS,FFS,LAF,LP,CPE,DA, full_state=1 for 2 cycles. Repeat with low_pkt_valid=0 -> LAF,LD.
- Invalid address, NUM_CH=3, data_in=3, pkt_valid=1 for 4 cycles -> DP for 4 cycles with drop_state=1, write_enb_reg=0, busy=0, then DA.
- Mid-packet in LD with dest_addr=1: soft_reset[0]=1 -> no effect; soft_reset[1]=1 -> DA next cycle. reset asserted in FFS -> DA, all outputs at reset values.

Source files
------------

// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - 1xN router controller FSM with invalid-address drop and bounded FIFO-drain wait
module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] dest_addr
);

    localparam int NSLOT = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W:0]   NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              tmo_d;
    logic              detect_add_q, lfd_q, ld_q, laf_q, full_q;
    logic              we_q, rst_int_q, busy_q, drop_q, tmo_q;

    // Flags padded to the full address space so unused addresses read as 0
    logic [NSLOT-1:0] empty_pad, srst_pad;
    for (genvar i = 0; i < NSLOT; i++) begin : g_pad
        if (i < NUM_CH) begin : g_real
            assign empty_pad[i] = fifo_empty[i];
            assign srst_pad[i]  = soft_reset[i];
        end else begin : g_none
            assign empty_pad[i] = 1'b0;
            assign srst_pad[i]  = 1'b0;
        end
    end

    logic addr_bad;
    assign addr_bad = ({1'b0, data_in} >= NUM_CH_V);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        tmo_d   = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    dest_d = data_in;
                    if (addr_bad) begin
                        state_d = DROP_PACKET;
                    end else if (empty_pad[data_in]) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_pad[dest_q]) begin
                    state_d = LOAD_FIRST_DATA;
                end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = DROP_PACKET;
                    tmo_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Read-timeout flush of the selected FIFO abandons the packet in flight
        if (srst_pad[dest_q] && (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET)) begin
            state_d = DECODE_ADDRESS;
            cnt_d   = '0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= DECODE_ADDRESS;
            cnt_q        <= '0;
            dest_q       <= '0;
            tmo_q        <= 1'b0;
            detect_add_q <= 1'b1;
            lfd_q        <= 1'b0;
            ld_q         <= 1'b0;
            laf_q        <= 1'b0;
            full_q       <= 1'b0;
            we_q         <= 1'b0;
            rst_int_q    <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dest_q       <= dest_d;
            tmo_q        <= tmo_d;
            detect_add_q <= (state_d == DECODE_ADDRESS);
            lfd_q        <= (state_d == LOAD_FIRST_DATA);
            ld_q         <= (state_d == LOAD_DATA);
            laf_q        <= (state_d == LOAD_AFTER_FULL);
            full_q       <= (state_d == FIFO_FULL_STATE);
            we_q         <= (state_d == LOAD_DATA) || (state_d == LOAD_AFTER_FULL) ||
                            (state_d == LOAD_PARITY);
            rst_int_q    <= (state_d == CHECK_PARITY_ERROR);
            busy_q       <= (state_d == LOAD_FIRST_DATA) || (state_d == WAIT_TILL_EMPTY) ||
                            (state_d == FIFO_FULL_STATE) || (state_d == LOAD_AFTER_FULL) ||
                            (state_d == LOAD_PARITY)     || (state_d == CHECK_PARITY_ERROR);
            drop_q       <= (state_d == DROP_PACKET);
        end
    end

    assign detect_add    = detect_add_q;
    assign lfd_state     = lfd_q;
    assign ld_state      = ld_q;
    assign laf_state     = laf_q;
    assign full_state    = full_q;
    assign write_enb_reg = we_q;
    assign rst_int_reg   = rst_int_q;
    assign busy          = busy_q;
    assign drop_state    = drop_q;
    assign timeout_err   = tmo_q;
    assign dest_addr     = dest_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb/tb_router_fsm_nch.sv - self-checking bench for router_fsm_nch (vector table, directed waits, random vs model)
module tb_router_fsm_nch;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;
    localparam int WAIT_TIMEOUT = 30;

    // Output vector order: detect,lfd,ld,laf,full,we,rst_int,busy,drop,timeout_err
    localparam logic [9:0] O_DA  = 10'b1000000000;
    localparam logic [9:0] O_LFD = 10'b0100000100;
    localparam logic [9:0] O_LD  = 10'b0010010000;
    localparam logic [9:0] O_LAF = 10'b0001010100;
    localparam logic [9:0] O_FFS = 10'b0000100100;
    localparam logic [9:0] O_LP  = 10'b0000010100;
    localparam logic [9:0] O_CPE = 10'b0000001100;
    localparam logic [9:0] O_WTE = 10'b0000000100;
    localparam logic [9:0] O_DP  = 10'b0000000010;

    localparam int S_DA = 0, S_WTE = 1, S_LFD = 2, S_LD = 3, S_FFS = 4,
                   S_LAF = 5, S_LP = 6, S_CPE = 7, S_DP = 8;

    logic clock = 1'b0;
    logic reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_empty, soft_reset;
    logic detect_add, lfd_state, ld_state, laf_state, full_state;
    logic write_enb_reg, rst_int_reg, busy, drop_state, timeout_err;
    logic [ADDR_W-1:0] dest_addr;

    router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
        .busy(busy), .drop_state(drop_state), .timeout_err(timeout_err), .dest_addr(dest_addr)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int tmo_seen = 0;

    // Reference model: phase of the packet, wait length so far, latched destination
    int m_state = S_DA;
    int m_waited = 0;
    int m_dest = 0;
    bit m_tmo = 0;

    typedef struct {
        logic r, pv, pd, lpv;
        logic [1:0] din;
        logic ff;
        logic [2:0] fe, sr;
        logic [9:0] exp_o;
        logic [1:0] exp_d;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [9:0] act_outs();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy, drop_state, timeout_err};
    endfunction

    function automatic logic [9:0] model_outs();
        logic [9:0] o;
        case (m_state)
            S_DA:    o = O_DA;
            S_WTE:   o = O_WTE;
            S_LFD:   o = O_LFD;
            S_LD:    o = O_LD;
            S_FFS:   o = O_FFS;
            S_LAF:   o = O_LAF;
            S_LP:    o = O_LP;
            S_CPE:   o = O_CPE;
            default: o = O_DP;
        endcase
        return o | {9'b0, m_tmo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit sel_flag(input logic [NUM_CH-1:0] v, input int a);
        return (a < NUM_CH) ? v[a] : 1'b0;
    endfunction

    task automatic model_step();
        int nxt;
        int din;
        bit tmo;
        if (reset) begin
            m_state = S_DA; m_waited = 0; m_dest = 0; m_tmo = 0;
            return;
        end
        nxt = m_state;
        tmo = 0;
        din = int'(data_in);
        if (m_state == S_DA) begin
            if (pkt_valid) begin
                m_dest = din;
                if (din >= NUM_CH) nxt = S_DP;
                else if (fifo_empty[din]) nxt = S_LFD;
                else begin nxt = S_WTE; m_waited = 0; end
            end
        end else if (m_state == S_WTE) begin
            m_waited++;
            if (sel_flag(fifo_empty, m_dest)) nxt = S_LFD;
            else if (WAIT_TIMEOUT != 0 && m_waited == WAIT_TIMEOUT) begin nxt = S_DP; tmo = 1; end
        end else if (m_state == S_LFD) nxt = S_LD;
        else if (m_state == S_LD) nxt = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
        else if (m_state == S_FFS) nxt = fifo_full ? S_FFS : S_LAF;
        else if (m_state == S_LAF) nxt = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
        else if (m_state == S_LP) nxt = S_CPE;
        else if (m_state == S_CPE) nxt = fifo_full ? S_FFS : S_DA;
        else if (m_state == S_DP) nxt = pkt_valid ? S_DP : S_DA;
        if (m_state != S_DA && m_state != S_DP && sel_flag(soft_reset, m_dest)) begin
            nxt = S_DA; m_waited = 0; tmo = 0;
        end
        m_state = nxt;
        m_tmo = tmo;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        if (timeout_err) tmo_seen++;
        chk("model_outs", 32'(act_outs()), 32'(model_outs()));
        chk("model_dest", 32'(dest_addr), 32'(m_dest[1:0]));
    endtask

    task automatic drive(input logic r, pv, pd, lpv, input logic [1:0] din,
                         input logic ff, input logic [2:0] fe, sr);
        reset = r; pkt_valid = pv; parity_done = pd; low_pkt_valid = lpv;
        data_in = din; fifo_full = ff; fifo_empty = fe; soft_reset = sr;
    endtask

    task automatic add(input logic r, pv, pd, lpv, input logic [1:0] din, input logic ff,
                       input logic [2:0] fe, sr, input logic [9:0] eo, input logic [1:0] ed);
        vec_t v;
        v.r = r; v.pv = pv; v.pd = pd; v.lpv = lpv; v.din = din; v.ff = ff;
        v.fe = fe; v.sr = sr; v.exp_o = eo; v.exp_d = ed;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wte;
        int tmo_base;
        drive(1, 0, 0, 0, 0, 0, 3'b000, 3'b000);

        // reset, then soft resets while idle
        add(1,0,0,0,0,0,3'b000,3'b000,O_DA,0);
        add(0,0,0,0,0,0,3'b000,3'b001,O_DA,0);
        add(0,0,0,0,0,0,3'b000,3'b010,O_DA,0);
        add(0,0,0,0,0,0,3'b000,3'b100,O_DA,0);
        // short packet to channel 2
        add(0,1,0,0,2,0,3'b100,3'b000,O_LFD,2);
        add(0,1,0,0,2,0,3'b100,3'b000,O_LD,2);
        add(0,1,0,0,2,0,3'b100,3'b000,O_LD,2);
        add(0,0,0,0,2,0,3'b100,3'b000,O_LP,2);
        add(0,0,0,0,2,0,3'b100,3'b000,O_CPE,2);
        add(0,0,0,0,2,0,3'b100,3'b000,O_DA,2);
        // invalid address dropped
        add(0,1,0,0,3,0,3'b111,3'b000,O_DP,3);
        add(0,1,0,0,0,0,3'b111,3'b000,O_DP,3);
        add(0,1,0,0,1,0,3'b111,3'b000,O_DP,3);
        add(0,1,0,0,2,0,3'b111,3'b000,O_DP,3);
        add(0,0,0,0,0,0,3'b111,3'b000,O_DA,3);
        // full stall, low_pkt_valid path
        add(0,1,0,0,0,0,3'b001,3'b000,O_LFD,0);
        add(0,1,0,0,0,0,3'b001,3'b000,O_LD,0);
        add(0,1,0,0,0,1,3'b001,3'b000,O_FFS,0);
        add(0,1,0,0,0,1,3'b001,3'b000,O_FFS,0);
        add(0,1,0,0,0,0,3'b001,3'b000,O_LAF,0);
        add(0,0,0,1,0,0,3'b001,3'b000,O_LP,0);
        add(0,0,0,0,0,0,3'b001,3'b000,O_CPE,0);
        add(0,0,0,0,0,0,3'b001,3'b000,O_DA,0);
        // full stall, resume loading; then soft reset of other / own channel
        add(0,1,0,0,1,0,3'b010,3'b000,O_LFD,1);
        add(0,1,0,0,1,0,3'b010,3'b000,O_LD,1);
        add(0,1,0,0,1,1,3'b010,3'b000,O_FFS,1);
        add(0,1,0,0,1,0,3'b010,3'b000,O_LAF,1);
        add(0,1,0,0,1,0,3'b010,3'b000,O_LD,1);
        add(0,1,0,0,1,0,3'b010,3'b001,O_LD,1);
        add(0,1,0,0,1,0,3'b010,3'b010,O_DA,1);
        // reset while stalled
        add(0,1,0,0,2,0,3'b100,3'b000,O_LFD,2);
        add(0,1,0,0,2,0,3'b100,3'b000,O_LD,2);
        add(0,1,0,0,2,1,3'b100,3'b000,O_FFS,2);
        add(1,1,0,0,2,1,3'b100,3'b000,O_DA,0);
        // parity_done wins in LAF
        add(0,1,0,0,0,0,3'b001,3'b000,O_LFD,0);
        add(0,1,0,0,0,0,3'b001,3'b000,O_LD,0);
        add(0,1,0,0,0,1,3'b001,3'b000,O_FFS,0);
        add(0,1,0,0,0,0,3'b001,3'b000,O_LAF,0);
        add(0,0,1,1,0,0,3'b001,3'b000,O_DA,0);
        // CPE with FIFO full, then soft reset out of FFS
        add(0,1,0,0,0,0,3'b001,3'b000,O_LFD,0);
        add(0,0,0,0,0,0,3'b001,3'b000,O_LD,0);
        add(0,0,0,0,0,0,3'b001,3'b000,O_LP,0);
        add(0,0,0,0,0,1,3'b001,3'b000,O_CPE,0);
        add(0,0,0,0,0,1,3'b001,3'b000,O_FFS,0);
        add(0,0,0,0,0,1,3'b001,3'b001,O_DA,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].pv, tbl[i].pd, tbl[i].lpv, tbl[i].din,
                  tbl[i].ff, tbl[i].fe, tbl[i].sr);
            step();
            chk($sformatf("tbl%0d_outs", i), 32'(act_outs()), 32'(tbl[i].exp_o));
            chk($sformatf("tbl%0d_dest", i), 32'(dest_addr), 32'(tbl[i].exp_d));
        end

        // short wait: FIFO 1 busy for 5 cycles
        tmo_base = tmo_seen;
        n_wte = 0;
        drive(0, 1, 0, 0, 1, 0, 3'b000, 3'b000);
        step();
        if (act_outs() == O_WTE) n_wte++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (act_outs() == O_WTE) n_wte++;
        end
        drive(0, 1, 0, 0, 1, 0, 3'b010, 3'b000);
        step();
        chk("short_wait_cycles", 32'(n_wte), 32'd5);
        chk("short_wait_lfd", 32'(act_outs()), 32'(O_LFD));
        drive(0, 0, 0, 0, 1, 0, 3'b010, 3'b000);
        for (int i = 0; i < 4; i++) step();
        chk("short_wait_done", 32'(act_outs()), 32'(O_DA));
        chk("short_wait_no_tmo", 32'(tmo_seen - tmo_base), 32'd0);

        // timeout: FIFO 1 never drains
        tmo_base = tmo_seen;
        drive(0, 1, 0, 0, 1, 0, 3'b000, 3'b000);
        step();
        n_wte = (act_outs() == O_WTE) ? 1 : 0;
        drive(0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
        for (int i = 0; i < 100; i++) begin
            step();
            if (drop_state) break;
            if (act_outs() == O_WTE) n_wte++;
        end
        chk("tmo_wte_cycles", 32'(n_wte), 32'(WAIT_TIMEOUT));
        chk("tmo_dp_outs", 32'(act_outs()), 32'(O_DP | 10'b1));
        step();
        chk("tmo_back_da", 32'(act_outs()), 32'(O_DA));
        chk("tmo_pulse_count", 32'(tmo_seen - tmo_base), 32'd1);

        // randomized traffic against the model
        fifo_empty = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) fifo_empty = 3'($urandom_range(0, 7));
            soft_reset    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
